// File: rtl/rec2pol_ctrl.sv
// Sequencer for the rec2pol CORDIC vectoring stage: folds the sample into the right
// half-plane, runs NITER iterations, then restores the full-range angle in 9Q10 degrees.
module rec2pol_ctrl #(
  parameter int unsigned NITER = 16,
  parameter int unsigned INW   = 129,
  parameter int unsigned AW    = 19
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [INW-1:0] x_in,
  input  logic signed [INW-1:0] y_in,
  output logic signed [INW-1:0] cordic_x,
  output logic signed [INW-1:0] cordic_y,
  output logic                  cordic_start,
  output logic                  cordic_enable,
  input  logic signed [AW-1:0]  cordic_angle,
  output logic signed [AW-1:0]  angle_out,
  output logic                  angle_valid,
  output logic                  sat,
  output logic                  busy
);

  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] ITER_LOAD = CW'(NITER - 1);
  localparam logic signed [INW-1:0] XMIN = {1'b1, {(INW-1){1'b0}}};
  localparam logic signed [INW-1:0] XMAX = {1'b0, {(INW-1){1'b1}}};
  localparam logic signed [AW:0] K_180 = (AW+1)'(184320);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, CAPT} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [INW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic                  quad_q, quad_d;
  logic                  sat_q, sat_d;
  logic signed [AW-1:0]  angle_q, angle_d;
  logic                  start_q, start_d;
  logic                  en_q, en_d;
  logic                  valid_q, valid_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic signed [INW-1:0] neg_x_c, neg_y_c;
  logic signed [AW:0]    ang_ext_c, ang_corr_c;

  // Saturating negation: the most-negative value has no positive counterpart.
  always_comb begin
    neg_x_c = (x_in == XMIN) ? XMAX : -x_in;
    neg_y_c = (y_in == XMIN) ? XMAX : -y_in;
  end

  // Undo the half-plane fold; zero counts as the lower side so -180 maps to +180.
  always_comb begin
    ang_ext_c = {cordic_angle[AW-1], cordic_angle};
    if (!quad_q) begin
      ang_corr_c = ang_ext_c;
    end else if (ang_ext_c[AW] || (ang_ext_c == '0)) begin
      ang_corr_c = ang_ext_c + K_180;
    end else begin
      ang_corr_c = ang_ext_c - K_180;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    quad_d  = quad_q;
    sat_d   = sat_q;
    angle_d = angle_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = LOAD;
          if (x_in[INW-1]) begin
            cx_d   = neg_x_c;
            cy_d   = neg_y_c;
            quad_d = 1'b1;
            sat_d  = (x_in == XMIN) || (y_in == XMIN);
          end else begin
            cx_d   = x_in;
            cy_d   = y_in;
            quad_d = 1'b0;
            sat_d  = 1'b0;
          end
        end
      end
      LOAD: begin
        state_d = ITER;
        cnt_d   = ITER_LOAD;
      end
      ITER: begin
        if (cnt_q == '0) begin
          state_d = CAPT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CAPT: begin
        state_d = IDLE;
        angle_d = AW'(ang_corr_c);
      end
      default: state_d = IDLE;
    endcase

    start_d = (state_d == LOAD);
    en_d    = (state_d == LOAD) || (state_d == ITER);
    valid_d = (state_q == CAPT);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      quad_q  <= 1'b0;
      sat_q   <= 1'b0;
      angle_q <= '0;
      start_q <= 1'b0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      quad_q  <= quad_d;
      sat_q   <= sat_d;
      angle_q <= angle_d;
      start_q <= start_d;
      en_q    <= en_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready      = ready_q;
  assign cordic_x      = cx_q;
  assign cordic_y      = cy_q;
  assign cordic_start  = start_q;
  assign cordic_enable = en_q;
  assign angle_out     = angle_q;
  assign angle_valid   = valid_q;
  assign sat           = sat_q;
  assign busy          = busy_q;

endmodule

// File: doc/rec2pol_ctrl.md
Name: rec2pol_ctrl

Overview:
- Upstream sequencer for the CORDIC vectoring stage `rec2pol`.
- Accepts one rectangular sample pair (x, y) over a valid/ready handshake and pre-rotates it into the right half-plane, where CORDIC vectoring converges.
- Drives the `rec2pol` start/enable pins for a fixed iteration count, captures the resulting angle, and applies the 180° quadrant correction.
- Emits a full-range angle, 9Q10 degrees in (-180,+180], with a one-cycle valid pulse to the bearing back-end.

Parameters:
- NITER, 16, number of CORDIC iterations (cycles `cordic_enable` is held high after the start cycle); must be at least 1 and no more than 16, the atan ROM depth.
- INW, 129, width of the signed x/y inputs.
- AW, 19, width of the signed 9Q10 angle.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  x_in/y_in valid
- in_ready  out  1  block can accept a sample
- x_in  in  INW  signed X component
- y_in  in  INW  signed Y component
- cordic_x  out  INW  pre-rotated X to `rec2pol` x
- cordic_y  out  INW  pre-rotated Y to `rec2pol` y
- cordic_start  out  1  to `rec2pol` start
- cordic_enable  out  1  to `rec2pol` enable
- cordic_angle  in  AW  from `rec2pol` angle (9Q10)
- angle_out  out  AW  corrected angle, 9Q10 degrees, range (-180,+180]
- angle_valid  out  1  one-cycle pulse, angle_out valid
- sat  out  1  input X was the most-negative value and was saturated; sampled with angle_valid
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - cordic_x, cordic_y, angle_out and the internal quad flag clear to 0.
  - cordic_start, cordic_enable, angle_valid, sat and busy clear to 0.
  - A reset mid-operation aborts the conversion; no angle_valid is produced.
- FSM states: IDLE, LOAD, ITER, CAPT.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&in_ready, latch the pre-rotated sample (below) into cordic_x/cordic_y and go to LOAD.
  - in_valid while busy is ignored; the source holds it.
- Pre-rotation, evaluated at the accept edge:
  - If x_in<0: cordic_x=-x_in, cordic_y=-y_in, quad=1.
  - Otherwise: pass x_in/y_in through unchanged, quad=0.
  - Negating the most-negative INW value saturates to the most-positive value and sets the sticky-per-sample sat flag. The same rule applies to y_in.
  - x_in=0 is not rotated.
- LOAD: one cycle with cordic_start=1 and cordic_enable=1; `rec2pol` loads its registers and resets its iteration counter. Next state is ITER.
- ITER:
  - cordic_start=0, cordic_enable=1 for exactly NITER cycles.
  - A down-counter loaded with NITER-1 on entry; leave ITER when it reaches 0.
  - cordic_x/cordic_y are held stable from LOAD until IDLE.
- CAPT:
  - cordic_enable=0, so `rec2pol` holds its result.
  - At the edge leaving CAPT, register angle_out and pulse angle_valid for the following cycle. State returns to IDLE, so in_ready=1 in the same cycle as angle_valid.
- Angle correction, with K = 180·1024 = 184320:
  - quad=0: angle_out = cordic_angle.
  - quad=1 and cordic_angle<=0: angle_out = cordic_angle + K.
  - quad=1 and cordic_angle>0: angle_out = cordic_angle - K.
  - Arithmetic is done in AW+1 bits, then truncated to AW; no overflow is possible, since |angle|<=184320 < 2^18.
- Latency: accept edge E0, `rec2pol` load at E1, iterations at E2..E(NITER+1), capture at E(NITER+2). angle_valid is high in the cycle after E(NITER+2), i.e. 18 edges after E0 for NITER=16.
- Throughput: one sample per NITER+3 cycles; back-to-back accept is allowed on the angle_valid cycle.
- Zero input (x=y=0): `rec2pol` returns 0, angle_out=0.
- angle_out holds its value between pulses until the next capture or reset.

Test Plan:
- Reset during ITER (drive reset=0 at E5) -> outputs and busy go to 0 immediately; no angle_valid; the next accepted sample completes normally.
- x=1.0, y=1.0 (16Q16: 65536, 65536) -> angle_valid exactly 18 edges after accept; angle_out≈46080 (45°) ±8 LSB; in_ready=0 throughout; cordic_start high for exactly one cycle.
- x=-65536, y=65536 -> quad=1, cordic_x=65536, cordic_y=-65536, cordic_angle≈-46080; angle_out≈138240 (135°) ±8 LSB. Then x=-65536, y=-65536 -> angle_out≈-138240 (-135°).
- x=-65536, y=0 -> angle_out=184320 (+180°) ±8 LSB, never -180°. Also x=0, y=65536 -> ≈92160 (90°); x=0, y=0 -> 0.
- x_in = most-negative 129-bit value, y=0 -> cordic_x = most-positive value, sat=1 with angle_valid, angle_out≈184320. The following normal sample reports sat=0.
- Back-to-back: in_valid held high with 4 samples -> accepts spaced exactly 19 cycles (NITER+3); each angle_valid is in the same cycle as in_ready; results are in order and match golden atan2 within ±8 LSB.
